// File: rtl/if_id_buffer.sv
// IF/ID pipeline stage: 2-entry skid buffer between fetch and decode, with MIPS field
// extraction on the head entry and a count of issued (popped) instructions.
module if_id_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm_sext,
    output logic              is_rtype,
    output logic [CNT_W-1:0]  issue_count
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] pc_q    [2];
    logic [DATA_W-1:0] pc_d    [2];
    logic [DATA_W-1:0] instr_q [2];
    logic [DATA_W-1:0] instr_d [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic              push, pop;

    // Ready depends only on registered occupancy, so no comb path from out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        issue_d = issue_q;

        // Decode already took the head, so a pop counts even in a flush cycle.
        if (pop) begin
            issue_d = issue_q + CntOne;
        end

        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) begin
                pc_d[tail_q]    = in_pc;
                instr_d[tail_q] = in_instr;
                tail_d          = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            issue_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= pc_d[i];
                instr_q[i] <= instr_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            issue_q <= issue_d;
        end
    end

    assign out_pc      = pc_q[head_q];
    assign out_instr   = instr_q[head_q];
    assign opcode      = out_instr[31:26];
    assign rs          = out_instr[25:21];
    assign rt          = out_instr[20:16];
    assign rd          = out_instr[15:11];
    assign shamt       = out_instr[10:6];
    assign funct       = out_instr[5:0];
    assign imm_sext    = {{(DATA_W-16){out_instr[15]}}, out_instr[15:0]};
    assign is_rtype    = (opcode == 6'd0);
    assign issue_count = issue_q;

endmodule
